// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: a valid/ready command in, a valid/ready response out.
// The ACCESS-phase timeout stops a hung slave from holding the bus forever.
module apb_master_bridge #(
   parameter int ADDR_W         = 8,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic              i_cmd_write,
   input  logic [ADDR_W-1:0] i_cmd_addr,
   input  logic [DATA_W-1:0] i_cmd_wdata,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [DATA_W-1:0] o_rsp_rdata,
   output logic              o_rsp_write,
   output logic              o_rsp_timeout,
   output logic [ADDR_W-1:0] o_paddr,
   output logic              o_pwrite,
   output logic              o_psel,
   output logic              o_penable,
   output logic [DATA_W-1:0] o_pwdata,
   input  logic [DATA_W-1:0] i_prdata,
   input  logic              i_pready
);

   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
   localparam int CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int LAST_I = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_t;

   state_t state;
   state_t state_nx;

   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_d;
   logic              expire;
   logic              load_cmd;
   logic              done;
   logic              psel_d;
   logic              penable_d;
   logic              rsp_valid_d;
   logic [DATA_W-1:0] rdata_d;
   logic              timeout_d;

   assign o_cmd_ready = (state == IDLE);
   assign expire = TO_EN && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (i_cmd_valid) state_nx = SETUP;
         end
         SETUP: begin
            state_nx = ACCESS;
         end
         ACCESS: begin
            if (i_pready || expire) state_nx = RESP;
         end
         RESP: begin
            if (i_rsp_ready) state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Next values of the registered outputs, derived from the upcoming state.
   always_comb begin
      psel_d      = (state_nx == SETUP) || (state_nx == ACCESS);
      penable_d   = (state_nx == ACCESS);
      rsp_valid_d = (state_nx == RESP);
      load_cmd    = (state == IDLE) && i_cmd_valid;
      done        = (state == ACCESS) && (i_pready || expire);
      rdata_d     = '0;
      if (i_pready && !o_pwrite) rdata_d = i_prdata;
      timeout_d   = !i_pready;
      cnt_d       = '0;
      if (state == ACCESS) begin
         cnt_d = cnt;
         if (cnt != CNT_MAX) cnt_d = cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         o_psel        <= 1'b0;
         o_penable     <= 1'b0;
         o_rsp_valid   <= 1'b0;
         o_paddr       <= '0;
         o_pwrite      <= 1'b0;
         o_pwdata      <= '0;
         o_rsp_rdata   <= '0;
         o_rsp_write   <= 1'b0;
         o_rsp_timeout <= 1'b0;
         cnt           <= '0;
      end else begin
         o_psel      <= psel_d;
         o_penable   <= penable_d;
         o_rsp_valid <= rsp_valid_d;
         cnt         <= cnt_d;
         if (load_cmd) begin
            o_paddr  <= i_cmd_addr;
            o_pwrite <= i_cmd_write;
            o_pwdata <= i_cmd_wdata;
         end
         if (done) begin
            o_rsp_rdata   <= rdata_d;
            o_rsp_write   <= o_pwrite;
            o_rsp_timeout <= timeout_d;
         end
      end
   end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB requester. Converts a valid/ready command stream into APB SETUP/ACCESS transfers and returns read data and status on a valid/ready response channel.
- Sits between a control-side sequencer (CPU model, test sequencer, DMA-lite) and memory-mapped APB slaves such as the peripheral wrappers on the GCD calculator.
- Includes an ACCESS-phase timeout so a hung slave cannot lock the bus.

Parameters:
ADDR_W, 8, APB address width
DATA_W, 32, APB data width
TIMEOUT_CYCLES, 16, maximum ACCESS-phase cycles before abort; 0 disables the timeout

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
i_cmd_valid  input  1  command valid
o_cmd_ready  output  1  command ready
i_cmd_write  input  1  1 = write, 0 = read
i_cmd_addr  input  ADDR_W  byte address
i_cmd_wdata  input  DATA_W  write data
o_rsp_valid  output  1  response valid
i_rsp_ready  input  1  response ready
o_rsp_rdata  output  DATA_W  read data (0 for writes and timeouts)
o_rsp_write  output  1  echo of the command type
o_rsp_timeout  output  1  transfer aborted by timeout
o_paddr  output  ADDR_W  APB address
o_pwrite  output  1  APB write
o_psel  output  1  APB select
o_penable  output  1  APB enable
o_pwdata  output  DATA_W  APB write data
i_prdata  input  DATA_W  APB read data
i_pready  input  1  APB ready

Behaviour:
- Clock and reset: one clock, clk. rstn is asynchronous and active-low; assertion immediately clears all state regardless of clk.
- Reset values: all outputs 0 except o_cmd_ready = 1; FSM in IDLE.
- Reset mid-transfer: psel/penable drop at once; no response is generated; the slave must be reset with the same rstn.
- Output timing: all APB and response outputs are registered. o_cmd_ready is combinational: (state == IDLE).
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - o_cmd_ready = 1.
  - On i_cmd_valid && o_cmd_ready, capture addr/write/wdata into o_paddr/o_pwrite/o_pwdata and go to SETUP.
  - Timeout counter clears.
- SETUP (exactly 1 cycle): psel = 1, penable = 0, then go to ACCESS.
- ACCESS: psel = 1, penable = 1. Each cycle, sample i_pready at the clock edge:
  - pready = 1: capture rdata (i_prdata for reads, 0 for writes), set rsp_timeout = 0, drop psel/penable, go to RESP.
  - pready = 0 and TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: abort. Drop psel/penable, set rsp_timeout = 1, rdata = 0, go to RESP.
  - Otherwise: increment the counter and stay in ACCESS.
  - Simultaneous pready and timeout expiry: pready wins (normal completion).
- RESP:
  - o_rsp_valid = 1; o_rsp_rdata, o_rsp_write and o_rsp_timeout are held stable.
  - On i_rsp_ready: o_rsp_valid falls and the FSM goes to IDLE.
  - Backpressure holds the FSM in RESP indefinitely; no new command is accepted.
- Address/data stability: o_paddr, o_pwrite, o_pwdata stay constant from SETUP through the end of ACCESS and keep their last values in IDLE/RESP (no toggling between transfers).
- Latency:
  - Minimum command-accept to o_rsp_valid = 3 cycles (accept T0, SETUP T1, ACCESS T2 with pready = 1, RESP T3).
  - Each slave wait state adds 1 cycle.
  - Back-to-back throughput is at best one transfer per 4 cycles (RESP ack, then IDLE accept).
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1 bit. The counter saturates and never wraps.
- Ignored inputs: i_cmd_* outside IDLE; i_pready/i_prdata outside ACCESS.
- Byte addressing: the address is passed through unaltered, with no alignment check. Reads of unmapped slave addresses return whatever the slave drives.

Test Plan:
1. Write cmd addr = 0x08, wdata = 0x0000_2418 to a slave with 1 wait state -> psel high T1–T3, penable high T2–T3, paddr/pwdata stable; rsp_valid at T4 with write = 1, timeout = 0, rdata = 0.
2. Read cmd addr = 0x0C, slave returns prdata = 0x0000_0006 with pready at first ACCESS cycle -> rsp_valid at T3, rdata = 0x6, write = 0.
3. Slave never asserts pready, TIMEOUT_CYCLES = 16 -> exactly 16 ACCESS cycles, then psel = penable = 0; rsp timeout = 1, rdata = 0. Repeat with pready on the 16th cycle -> timeout = 0.
4. Hold i_rsp_ready = 0 for 5 cycles after a read -> rsp_valid and rdata stable; cmd_ready = 0; a new cmd_valid is not accepted. Release -> IDLE, cmd_ready = 1 next cycle.
5. Assert rstn = 0 asynchronously mid-ACCESS -> psel/penable/rsp_valid = 0 before the next clk edge; cmd_ready = 1. After release, the next command completes normally.
6. Back-to-back write 0x00 = 0x1, write 0x08 = 0x0A0F, then read 0x04 polls against the GCD peripheral wrapper until bit0 = 1, then read 0x0C -> rdata = 0x5, no timeouts.
